// File: rtl/bfp16_wcol_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bfp16_wcol_loader                                                         |
// | Buffers DEPTH BFP16 weights, shifts them into a weight-stationary PE      |
// | column, then holds the column in compute until the tile completes.        |
// | Optional macro: WLOAD_PREFETCH_EN (ping-pong prefetch during HOLD).       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bfp16_wcol_loader #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_valid,
    input  logic [15:0] w_data,
    output logic        w_ready,
    input  logic        tile_done,
    output logic [15:0] weight,
    output logic        ctrl,
    output logic        loaded,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
`ifdef WLOAD_PREFETCH_EN
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
`endif

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic          w_accept;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [15:0]   w_rd_data;
    logic [15:0]   r_weight;
    logic          r_ctrl;
    logic          r_loaded;
    logic          r_busy;

`ifdef WLOAD_PREFETCH_EN
    logic          r_bank;
    logic          w_bank_n;
    logic          w_wr_bank;
`endif

    // w_ready is gated by reset so nothing is accepted while held in reset
`ifdef WLOAD_PREFETCH_EN
    assign w_ready = rst && ((r_state == S_FILL) ||
                             ((r_state == S_HOLD) && (r_cnt != C_FULL)));
`else
    assign w_ready = rst && (r_state == S_FILL);
`endif

    assign w_accept = w_valid && w_ready;
    assign w_wr_idx = r_cnt[AW-1:0];
    assign w_rd_idx = w_cnt_n[AW-1:0];

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_wr_en   = 1'b0;
`ifdef WLOAD_PREFETCH_EN
        w_bank_n  = r_bank;
`endif
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_state_n = S_SHIFT;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + C_ONE;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == C_LAST) begin
                    w_state_n = S_HOLD;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + C_ONE;
                end
            end
            S_HOLD: begin
`ifdef WLOAD_PREFETCH_EN
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    w_cnt_n = r_cnt + C_ONE;
                end
                // The prefetched bank becomes active whether full or partial
                if (tile_done) begin
                    w_bank_n = ~r_bank;
                    if (w_cnt_n == C_FULL) begin
                        w_state_n = S_SHIFT;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = S_FILL;
                    end
                end
`else
                if (tile_done) begin
                    w_state_n = S_FILL;
                end
`endif
            end
            default: begin
                w_state_n = S_FILL;
                w_cnt_n   = '0;
            end
        endcase
    end

`ifdef WLOAD_PREFETCH_EN
    logic [15:0] r_buf [2][DEPTH];

    // FILL writes the active bank, HOLD prefetches into the other one
    assign w_wr_bank = (r_state == S_HOLD) ? ~r_bank : r_bank;
    assign w_rd_data = r_buf[w_bank_n][w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_bank][w_wr_idx] <= w_data;
        end
    end
`else
    logic [15:0] r_buf [DEPTH];

    assign w_rd_data = r_buf[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= w_data;
        end
    end
`endif

    // Outputs are registered from next-state values so SHIFT word j
    // appears exactly in shift cycle j
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FILL;
            r_cnt    <= '0;
            r_weight <= 16'h0000;
            r_ctrl   <= 1'b1;
            r_loaded <= 1'b0;
            r_busy   <= 1'b0;
`ifdef WLOAD_PREFETCH_EN
            r_bank   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_weight <= (w_state_n == S_SHIFT) ? w_rd_data : 16'h0000;
            r_ctrl   <= (w_state_n != S_SHIFT);
            r_loaded <= (w_state_n == S_HOLD) && (r_state != S_HOLD);
            r_busy   <= (w_state_n != S_FILL);
`ifdef WLOAD_PREFETCH_EN
            r_bank   <= w_bank_n;
`endif
        end
    end

    assign weight = r_weight;
    assign ctrl   = r_ctrl;
    assign loaded = r_loaded;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bfp16_wcol_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bfp16_wcol_loader                                                      |
// | Randomized and directed bench against a queue-based tile model.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_bfp16_wcol_loader;
    localparam int DEPTH = 8;
`ifdef WLOAD_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        w_valid;
    logic [15:0] w_data;
    logic        w_ready;
    logic        tile_done;
    logic [15:0] weight;
    logic        ctrl;
    logic        loaded;
    logic        busy;

    bfp16_wcol_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .tile_done (tile_done),
        .weight    (weight),
        .ctrl      (ctrl),
        .loaded    (loaded),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Tile-level model: words collected so far, words still to shift out
    logic [15:0] fillq[$];
    logic [15:0] shiftq[$];
    logic        holding;
    logic [15:0] e_weight;
    logic        e_ctrl;
    logic        e_loaded;
    logic        e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        fillq.delete();
        shiftq.delete();
        holding  = 1'b0;
        e_weight = 16'h0000;
        e_ctrl   = 1'b1;
        e_loaded = 1'b0;
        e_busy   = 1'b0;
    endtask

    function automatic logic model_ready();
        if (!rst) return 1'b0;
        if (shiftq.size() > 0) return 1'b0;
        if (holding) return PREFETCH && (fillq.size() < DEPTH);
        return 1'b1;
    endfunction

    task automatic model_edge(input logic acc, input logic [15:0] d, input logic td);
        logic hold_start;
        hold_start = 1'b0;
        if (shiftq.size() > 0) begin
            shiftq.delete(0);
            if (shiftq.size() == 0) begin
                holding    = 1'b1;
                hold_start = 1'b1;
            end
        end else if (holding) begin
            if (acc) fillq.push_back(d);
            if (td) begin
                holding = 1'b0;
                if (fillq.size() == DEPTH) begin
                    shiftq = fillq;
                    fillq.delete();
                end
            end
        end else begin
            if (acc) fillq.push_back(d);
            if (fillq.size() == DEPTH) begin
                shiftq = fillq;
                fillq.delete();
            end
        end
        if (shiftq.size() > 0) begin
            e_weight = shiftq[0]; e_ctrl = 1'b0; e_loaded = 1'b0; e_busy = 1'b1;
        end else if (holding) begin
            e_weight = 16'h0000; e_ctrl = 1'b1; e_loaded = hold_start; e_busy = 1'b1;
        end else begin
            e_weight = 16'h0000; e_ctrl = 1'b1; e_loaded = 1'b0; e_busy = 1'b0;
        end
    endtask

    task automatic chk_outs(input string pfx);
        chk({pfx, "weight"}, 32'(weight), 32'(e_weight));
        chk({pfx, "ctrl"},   32'(ctrl),   32'(e_ctrl));
        chk({pfx, "loaded"}, 32'(loaded), 32'(e_loaded));
        chk({pfx, "busy"},   32'(busy),   32'(e_busy));
    endtask

    // One clock: drive at edge+1, check w_ready, then check registered outputs
    task automatic step(input logic v, input logic [15:0] d, input logic td);
        logic acc;
        w_valid   = v;
        w_data    = d;
        tile_done = td;
        #1;
        chk("w_ready", 32'(w_ready), 32'(model_ready()));
        acc = v && model_ready();
        @(posedge clk);
        #1;
        model_edge(acc, d, td);
        chk_outs("");
    endtask

    task automatic idle(input int n, input logic td);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, td);
    endtask

    task automatic feed(input logic [15:0] base, input logic [15:0] inc,
                        input int cnt, input logic gap, input logic gap_td);
        logic [15:0] w;
        w = base;
        for (int i = 0; i < cnt; i++) begin
            step(1'b1, w, 1'b0);
            if (gap) step(1'b0, 16'hDEAD, gap_td);
            w = w + inc;
        end
    endtask

    logic [15:0] t1 [DEPTH];

    initial begin
        t1[0] = 16'h3F80; t1[1] = 16'h4000; t1[2] = 16'h4040; t1[3] = 16'h4080;
        t1[4] = 16'h40A0; t1[5] = 16'h40C0; t1[6] = 16'h40E0; t1[7] = 16'h4100;

        rst = 1'b0; w_valid = 1'b0; w_data = 16'h0; tile_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_ready", 32'(w_ready), 32'(1'b0));
        chk_outs("rst_");
        rst = 1'b1;

        // Back-to-back tile, then hold and release
        for (int i = 0; i < DEPTH; i++) step(1'b1, t1[i], 1'b0);
        idle(12, 1'b0);
        step(1'b0, 16'h0, 1'b1);

        // Gapped tile with tile_done pulsed in FILL and SHIFT
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, t1[i], 1'b0);
            step(1'b0, 16'hBEEF, 1'b1);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, i[0]);
        idle(3, 1'b0);
        step(1'b0, 16'h0, 1'b1);

        // Asynchronous reset in the 4th shift cycle
        feed(16'h4200, 16'h0010, DEPTH, 1'b0, 1'b0);
        idle(3, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        chk_outs("arst_");
        chk("arst_w_ready", 32'(w_ready), 32'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk_outs("arst_hold_");
        rst = 1'b1;
        feed(16'h4300, 16'h0001, DEPTH, 1'b0, 1'b0);
        idle(10, 1'b0);
        step(1'b0, 16'h0, 1'b1);

`ifdef WLOAD_PREFETCH_EN
        // Full prefetch during HOLD, then direct to SHIFT
        feed(16'h3F00, 16'h0001, DEPTH, 1'b0, 1'b0);
        idle(9, 1'b0);
        feed(16'hC0A0, 16'h0002, DEPTH, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        idle(10, 1'b0);
        // Partial prefetch: 5 in HOLD, tile_done, 3 in FILL
        feed(16'hC100, 16'h0003, 5, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        feed(16'hC10F, 16'h0003, 3, 1'b0, 1'b0);
        idle(10, 1'b0);
        // Last prefetch word in the same cycle as tile_done
        feed(16'hC200, 16'h0004, DEPTH - 1, 1'b0, 1'b0);
        step(1'b1, 16'hC2FF, 1'b1);
        idle(10, 1'b0);
        step(1'b0, 16'h0, 1'b1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 16'($urandom()), ($urandom_range(0, 6) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bfp16_wcol_loader.md
Name: bfp16_wcol_loader

Overview:
- Weight-side feeder directly upstream of the BFP16 weight-stationary PE column; drives its `weight` and `ctrl` inputs.
- Collects DEPTH BFP16 weights (1b sign, 8b exp, 7b frac) over a valid/ready stream into a local buffer.
- Shifts the weights into the column on DEPTH consecutive cycles with ctrl=0, so the shift never stalls mid-tile.
- Then holds ctrl=1 (PE HOLD/compute) until the compute controller signals tile completion.

Parameters:
DEPTH, 8, PEs per column = weights per tile (≥2)
CW, $clog2(DEPTH)+1, word/shift counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
w_valid  input  1  upstream weight word valid
w_data  input  16  BFP16 weight word, passed bit-exact (no arithmetic)
w_ready  output  1  loader accepts w_data this cycle
tile_done  input  1  one-cycle pulse from compute ctrl: current tile finished
weight  output  16  to PE column weight input (top PE)
ctrl  output  1  to PE column ctrl; 1 = HOLD/compute, 0 = shift weights
loaded  output  1  one-cycle pulse: tile fully resident in column
busy  output  1  1 in SHIFT or HOLD

Behaviour:
- Reset (rst=0, async): state=FILL, counters=0, weight=16'h0, ctrl=1, w_ready=0, loaded=0, busy=0. Buffers are not reset.
- Reset mid-SHIFT/HOLD: abort immediately. Partially shifted column contents are don't-care.
- All outputs are registered except w_ready, which is a decode of state/count.
- Accept rule: a word is taken on a cycle with w_valid && w_ready.
- FILL:
  - w_ready=1, ctrl=1, busy=0.
  - Accepted word k (k=0..DEPTH-1) is stored at buf[k]; counter increments.
  - w_valid gaps are allowed; the counter holds.
  - When word DEPTH-1 is accepted, next state=SHIFT and the counter clears.
- SHIFT:
  - Lasts exactly DEPTH cycles, w_ready=0, ctrl=0, busy=1.
  - Shift cycle j drives weight=buf[j].
  - First SHIFT cycle is the cycle after the last accept (1-cycle accept-to-shift latency).
  - buf[0] ends in PE row 0 (bottom); buf[DEPTH-1] ends in row DEPTH-1.
  - After cycle DEPTH-1, next state=HOLD.
- HOLD:
  - ctrl=1, weight=16'h0, busy=1.
  - loaded=1 on the first HOLD cycle only.
  - Stays in HOLD until tile_done=1, then next state=FILL.
- tile_done outside HOLD: ignored and not remembered.
- w_valid outside the ready window: no effect; upstream must hold data.
- Total cycles from the first accept of a back-to-back stream to loaded: DEPTH + DEPTH.

Optional Feature:
Macro WLOAD_PREFETCH_EN.
- Defined:
  - Two buffer banks, selected by a ping-pong pointer.
  - w_ready=1 in HOLD as well as FILL, while the inactive bank is not full.
  - Words accepted in HOLD fill the inactive bank.
  - On tile_done with the inactive bank full (including the last word accepted in the same cycle as tile_done): go directly to SHIFT next cycle and swap banks; the loaded pulse follows as in base mode.
  - On tile_done with the inactive bank partial: go to FILL and continue counting from the current count into that bank.
  - w_ready=0 once the inactive bank is full.
- Undefined:
  - Single bank; w_ready=0 in HOLD; behaviour exactly as above.

Test Plan:
1. Reset, then weights 16'h3F80,16'h4000,...(8 words) back-to-back, w_valid=1 -> w_ready drops after the 8th; weight=3F80..(8th word) on 8 consecutive ctrl=0 cycles starting 1 cycle after the 8th accept; loaded pulses 1 cycle after the last shift; ctrl=1 and busy=1 thereafter.
2. Same 8 words with w_valid low every other cycle -> identical SHIFT sequence, never a ctrl=0 cycle with a missing word, SHIFT exactly 8 cycles.
3. tile_done pulsed in FILL and in SHIFT -> ignored, HOLD entered normally; tile_done in HOLD -> FILL next cycle, w_ready=1.
4. rst asserted in the 4th SHIFT cycle -> same-cycle (asynchronous) ctrl=1, weight=0, busy=0; after release, a new 8-word tile loads correctly from word 0.
5. WLOAD_PREFETCH_EN: during HOLD supply 8 words 16'hC0A0.. then tile_done -> SHIFT starts next cycle with no FILL state, weights from the second bank.
6. WLOAD_PREFETCH_EN: 5 words in HOLD, tile_done, 3 more words -> SHIFT emits all 8 in order.
7. WLOAD_PREFETCH_EN: 8th word accepted in the same cycle as tile_done -> direct to SHIFT.
